reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the dual-issue datapath; next generation of the single-write, 2-read MIPS register file.
- Provides 2 combinational read ports, 2 synchronous write ports with fixed priority, and a per-register busy scoreboard.
- The decode stage uses the scoreboard for RAW hazard detection.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/reg_file_mp.sv | 131 +++++++++++++
 tb/tb_reg_file_mp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// ----------------------------------------------------------------------------
// reg_file_mp
// Multi-port register file for the dual-issue datapath: two combinational
// read ports, two synchronous write ports (wr1 has priority over wr0) and a
// per-register busy scoreboard with a registered population count.
// Register 0 always reads as zero and is never busy.
//
// Optional feature (macro REG_FILE_MP_BYPASS_EN):
//   When defined, a read address that matches an enabled, nonzero write
//   address in the same cycle returns that write data combinationally
//   (wr1 over wr0), and its busy flag is forced low unless the same cycle
//   also issues to that register.
//   When undefined, reads see the stored array and stored busy bits only.
// ----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     cnt_next;

    logic wr0_live;
    logic wr1_live;

    assign wr0_live = wr0_en && (wr0_addr != '0);
    assign wr1_live = wr1_en && (wr1_addr != '0);

    // Storage array: async clear, then wr0 followed by wr1 so wr1 wins a collision.
    // NOTE: the array is built from flops because it must clear asynchronously; a
    // resettable memory cannot map onto a RAM macro, so keep NUM_REGS modest.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here; the later wr1 assignment overrides
            // wr0 for the same address within one edge, which is the priority rule.
            if (wr0_live) regs[wr0_addr] <= wr0_data;
            if (wr1_live) regs[wr1_addr] <= wr1_data;
        end
    end

    // Next busy vector: clears from writes, then issue set so a new producer wins.
    always_comb begin
        // NOTE: start from the current vector so every path assigns busy_next and
        // no latch is inferred.
        busy_next = busy;
        if (wr0_en) busy_next[wr0_addr] = 1'b0;
        if (wr1_en) busy_next[wr1_addr] = 1'b0;
        if (iss_en) busy_next[iss_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        cnt_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Scoreboard and busy count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // Read port A: stored data/busy, optionally overridden by a same-cycle write.
    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (rstn && rd_addr_a != '0) begin
            if (wr1_en && wr1_addr == rd_addr_a) begin
                rd_data_a = wr1_data;
                rd_busy_a = iss_en && (iss_addr == rd_addr_a);
            end else if (wr0_en && wr0_addr == rd_addr_a) begin
                rd_data_a = wr0_data;
                rd_busy_a = iss_en && (iss_addr == rd_addr_a);
            end
        end
`endif
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
`ifdef REG_FILE_MP_BYPASS_EN
        if (rstn && rd_addr_b != '0) begin
            if (wr1_en && wr1_addr == rd_addr_b) begin
                rd_data_b = wr1_data;
                rd_busy_b = iss_en && (iss_addr == rd_addr_b);
            end else if (wr0_en && wr0_addr == rd_addr_b) begin
                rd_data_b = wr0_data;
                rd_busy_b = iss_en && (iss_addr == rd_addr_b);
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// ----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed vector table, hand-written reset/bypass sequences and a randomized
// run against an array-based reference model of reg_file_mp.
// Follows REG_FILE_MP_BYPASS_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2 ** AW;
`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_busy_a, rd_busy_b;
    logic          wr0_en, wr1_en, iss_en;
    logic [AW-1:0] wr0_addr, wr1_addr, iss_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [AW:0]   busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_busy_a (rd_busy_a),
        .rd_busy_b (rd_busy_b),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Apply one clock edge of architectural rules to the model.
    function automatic void model_update();
        if (!rstn) return;
        if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
        if (wr0_en) m_busy[wr0_addr] = 1'b0;
        if (wr1_en) m_busy[wr1_addr] = 1'b0;
        if (iss_en) m_busy[iss_addr] = 1'b1;
        m_busy[0] = 1'b0;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && rstn && wr1_en && wr1_addr == a) return wr1_data;
        if (BYP && rstn && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && rstn && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)))
            return iss_en && iss_addr == a;
        return m_busy[a];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
        logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
        logic          ie;  logic [AW-1:0] ia;
        logic [AW-1:0] ra;  logic [AW-1:0] rb;
        logic [DW-1:0] ea;  logic [DW-1:0] eb;
        logic          eba; logic          ebb;
        int            ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input vec_t v);
        @(negedge clk);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_addr = v.ia;
        rd_addr_a = v.ra; rd_addr_b = v.rb;
        #2;
    endtask

    task automatic edge_update();
        @(posedge clk);
        model_update();
    endtask

    function automatic vec_t mk(logic w0e, int w0a, logic [DW-1:0] w0d,
                                logic w1e, int w1a, logic [DW-1:0] w1d,
                                logic ie, int ia, int ra, int rb);
        vec_t v;
        v.w0e = w0e; v.w0a = AW'(w0a); v.w0d = w0d;
        v.w1e = w1e; v.w1a = AW'(w1a); v.w1d = w1d;
        v.ie = ie;   v.ia = AW'(ia);
        v.ra = AW'(ra); v.rb = AW'(rb);
        v.ea = '0; v.eb = '0; v.eba = 1'b0; v.ebb = 1'b0; v.ecnt = 0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, logic [DW-1:0] ea, logic [DW-1:0] eb,
                                logic eba, logic ebb, int ecnt);
        vec_t r = v;
        r.ea = ea; r.eb = eb; r.eba = eba; r.ebb = ebb; r.ecnt = ecnt;
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    vec_t idle;
    vec_t cur;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        {wr0_en, wr1_en, iss_en} = '0;
        {wr0_addr, wr1_addr, iss_addr, rd_addr_a, rd_addr_b} = '0;
        {wr0_data, wr1_data} = '0;
        model_reset();

        // Reset state
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("reset_rd_data_a", rd_data_a, '0);
        check("reset_busy_cnt", DW'(busy_cnt), '0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table: priority, zero register, scoreboard
        vecs.push_back(ex(mk(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 7, 0),
                          BYP ? 32'h2222 : 32'h0, 0, 0, 0, 0));
        vecs.push_back(ex(mk(1, 3, 32'h3333, 1, 4, 32'h4444, 0, 0, 7, 3),
                          32'h2222, BYP ? 32'h3333 : 32'h0, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 4),
                          32'h3333, 32'h4444, 0, 0, 0));
        vecs.push_back(ex(mk(1, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0),
                          0, 0, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0),
                          0, 0, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 10, 9, 10),
                          0, 0, 1, 0, 1));
        vecs.push_back(ex(mk(1, 9, 32'hAAAA, 0, 0, 0, 1, 9, 9, 10),
                          BYP ? 32'hAAAA : 32'h0, 0, 1, 1, 2));
        vecs.push_back(ex(mk(1, 9, 32'h9999, 1, 10, 32'hBBBB, 0, 0, 9, 10),
                          BYP ? 32'h9999 : 32'hAAAA, BYP ? 32'hBBBB : 32'h0,
                          !BYP, !BYP, 2));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 10),
                          32'h9999, 32'hBBBB, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 1, 5, 32'h55, 0, 0, 5, 9),
                          BYP ? 32'h55 : 32'h0, 32'h9999, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0),
                          32'h55, 0, 0, 0, 0));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0),
                          32'h55, 0, 1, 0, 1));
        vecs.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0),
                          32'h55, 0, 1, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check($sformatf("vec%0d_rd_data_a", i), rd_data_a, vecs[i].ea);
            check($sformatf("vec%0d_rd_data_b", i), rd_data_b, vecs[i].eb);
            check($sformatf("vec%0d_rd_busy_a", i), DW'(rd_busy_a), DW'(vecs[i].eba));
            check($sformatf("vec%0d_rd_busy_b", i), DW'(rd_busy_b), DW'(vecs[i].ebb));
            check($sformatf("vec%0d_busy_cnt", i), DW'(busy_cnt), DW'(vecs[i].ecnt));
            edge_update();
        end

        // Bypass sequence on r12
        drive(mk(1, 12, 32'h0BAD, 0, 0, 0, 0, 0, 0, 0));
        edge_update();
        drive(mk(0, 0, 0, 1, 12, 32'hCAFE0001, 0, 0, 0, 12));
        check("bypass_same_cycle", rd_data_b, BYP ? 32'hCAFE0001 : 32'h0BAD);
        edge_update();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12));
        check("bypass_next_cycle", rd_data_b, 32'hCAFE0001);
        edge_update();

        // Mid-cycle reset with data and a busy register present
        drive(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 6, 0, 0));
        edge_update();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 6));
        check("pre_reset_r5", rd_data_a, 32'hDEADBEEF);
        check("pre_reset_cnt", DW'(busy_cnt), 32'd1);
        check("pre_reset_busy_r6", DW'(rd_busy_b), 32'd1);
        edge_update();
        #3 rstn = 1'b0;
        model_reset();
        #1;
        check("midreset_r5", rd_data_a, '0);
        check("midreset_busy_r6", DW'(rd_busy_b), '0);
        check("midreset_cnt", DW'(busy_cnt), '0);
        drive(mk(1, 6, 32'h77, 0, 0, 0, 1, 7, 6, 7));
        edge_update();
        @(negedge clk);
        rstn = 1'b1;
        wr0_en = 1'b0; iss_en = 1'b0;
        #2;
        check("reset_ignores_write", rd_data_a, '0);
        check("reset_ignores_issue", DW'(busy_cnt), '0);
        edge_update();

        // Randomized run against the reference model
        for (int c = 0; c < 10000; c++) begin
            cur = mk($urandom_range(0, 1), rnd_addr(), $urandom,
                     $urandom_range(0, 1), rnd_addr(), $urandom,
                     $urandom_range(0, 1), rnd_addr(), rnd_addr(), rnd_addr());
            drive(cur);
            check("rnd_rd_data_a", rd_data_a, exp_data(rd_addr_a));
            check("rnd_rd_data_b", rd_data_b, exp_data(rd_addr_b));
            check("rnd_rd_busy_a", DW'(rd_busy_a), DW'(exp_busy(rd_addr_a)));
            check("rnd_rd_busy_b", DW'(rd_busy_b), DW'(exp_busy(rd_addr_b)));
            check("rnd_busy_cnt", DW'(busy_cnt), DW'(model_cnt()));
            edge_update();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
